// File: rtl/stream_source_if.sv
// Core-port handshake bundle between an input-stream writer and a TIS core port.
// The writer drives write/out; the core answers with its read strobe.
interface stream_source_if;
  logic        write;
  logic [10:0] out;
  logic        read;

  modport master (output write, output out, input read);
  modport slave  (input write, input out, output read);
endinterface

// File: rtl/stream_source.sv
// Input-stream node: host preloads a FIFO, then values are handed to a TIS core port one at a time.
// Optional clamp-to-TIS-range on enqueue with a sticky sat_seen flag when STREAM_SAT_EN is defined.
module stream_source #(
  parameter int unsigned DEPTH = 39,
  parameter int unsigned AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [10:0]          load_data,
  output logic                 load_ready,
  input  logic                 start,
  stream_source_if.master      bus,
  output logic [AW-1:0]        count,
  output logic [AW-1:0]        sent,
  output logic                 done
`ifdef STREAM_SAT_EN
  ,
  output logic                 sat_seen
`endif
);

  typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  state_t          state, state_n;
  logic [AW-1:0]   head, head_n, tail, tail_n, cnt, cnt_n, sent_q, sent_n;
  logic            write_q, write_n;
  logic [10:0]     out_q, out_n;
  logic            push, go_present;
  logic [10:0]     word_in;
  logic            clamped;
  logic [10:0]     mem [DEPTH];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef STREAM_SAT_EN
  localparam logic signed [10:0] VMAX = 11'sd999;
  localparam logic signed [10:0] VMIN = -11'sd999;

  always_comb begin
    clamped = 1'b1;
    if ($signed(load_data) > VMAX)      word_in = VMAX;
    else if ($signed(load_data) < VMIN) word_in = VMIN;
    else begin
      word_in = load_data;
      clamped = 1'b0;
    end
  end

  logic sat_q;
  always_ff @(posedge clk) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= (go_present ? 1'b0 : sat_q) | (push & clamped);
  end
  assign sat_seen = sat_q;
`else
  assign word_in = load_data;
  assign clamped = 1'b0;
`endif

  assign load_ready = (state == IDLE) && (cnt != FULL);
  assign count      = cnt;
  assign sent       = sent_q;
  assign done       = (state == DONE);
  assign bus.write  = write_q;
  assign bus.out    = out_q;

  always_comb begin
    state_n    = state;
    head_n     = head;
    tail_n     = tail;
    cnt_n      = cnt;
    sent_n     = sent_q;
    write_n    = write_q;
    out_n      = out_q;
    push       = 1'b0;
    go_present = 1'b0;
    case (state)
      IDLE: begin
        write_n = 1'b0;
        push    = load_valid && load_ready;
        if (push) begin
          tail_n = nxt(tail);
          cnt_n  = cnt + 1'b1;
        end
        if (start) begin
          if (cnt_n != '0) begin
            state_n    = PRESENT;
            go_present = 1'b1;
            sent_n     = '0;
            write_n    = 1'b1;
            // An empty FIFO taking a same-cycle push has not stored the word yet.
            out_n      = (cnt == '0) ? word_in : mem[head];
          end else begin
            state_n = DONE;
          end
        end
      end
      PRESENT: begin
        if (write_q && bus.read) begin
          head_n  = nxt(head);
          cnt_n   = cnt - 1'b1;
          sent_n  = sent_q + 1'b1;
          write_n = 1'b0;
          if (cnt == AW'(1)) state_n = DONE;
        end else if (!write_q) begin
          write_n = 1'b1;
          out_n   = mem[head];
        end
      end
      DONE: begin
        write_n = 1'b0;
        if (start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      sent_q  <= '0;
      write_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= state_n;
      head    <= head_n;
      tail    <= tail_n;
      cnt     <= cnt_n;
      sent_q  <= sent_n;
      write_q <= write_n;
      out_q   <= out_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= word_in;
  end

endmodule
